// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared types and helpers for the HyperBus burst splitter
package hyperbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_RX = 3'd3,
    S_DONE    = 3'd4
  } splitter_state_t;

  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/hyperbus_chunk_calc.sv
// rtl/hyperbus_chunk_calc.sv - size of the next PHY transaction from address, remaining length and space
module hyperbus_chunk_calc
  import hyperbus_pkg::*;
#(
  parameter int LEN_WIDTH      = 16,
  parameter int MAX_BURST      = 256,
  parameter int BOUNDARY_WORDS = 1024,
  parameter int BND_BITS       = $clog2(BOUNDARY_WORDS)
) (
  input  logic [BND_BITS-1:0]  addr_lo_i,
  input  logic [LEN_WIDTH-1:0] remaining_i,
  input  logic                 reg_space_i,
  output logic [LEN_WIDTH-1:0] chunk_o
);

  localparam int CW = LEN_WIDTH + 1;

  logic [CW-1:0] w_offset;
  logic [CW-1:0] w_to_bnd;

  assign w_offset = CW'(addr_lo_i);
  assign w_to_bnd = CW'(BOUNDARY_WORDS) - w_offset;

  // The minimum never exceeds remaining, so truncating back to LEN_WIDTH is lossless.
  assign chunk_o = reg_space_i ? LEN_WIDTH'(1)
                 : LEN_WIDTH'(min3(32'(remaining_i), 32'(MAX_BURST), 32'(w_to_bnd)));

endmodule

// File: rtl/hyperbus_burst_splitter.sv
// rtl/hyperbus_burst_splitter.sv - splits a linear word burst into PHY transactions and tracks read completion
module hyperbus_burst_splitter
  import hyperbus_pkg::*;
#(
  parameter int NR_CS          = 2,
  parameter int BURST_WIDTH    = 12,
  parameter int LEN_WIDTH      = 16,
  parameter int MAX_BURST      = 256,
  parameter int BOUNDARY_WORDS = 1024,
  parameter int CS_ADDR_BIT    = 23
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_addr_i,
  input  logic [LEN_WIDTH-1:0]   req_len_i,
  input  logic                   req_write_i,
  input  logic                   req_reg_space_i,
  output logic                   trans_valid_o,
  input  logic                   trans_ready_i,
  output logic [31:0]            trans_address_o,
  output logic [NR_CS-1:0]       trans_cs_o,
  output logic                   trans_write_o,
  output logic [BURST_WIDTH-1:0] trans_burst_o,
  output logic                   trans_address_space_o,
  input  logic                   rx_valid_i,
  input  logic                   rx_ready_i,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int          CS_W     = $clog2(NR_CS);
  localparam int          BND_BITS = $clog2(BOUNDARY_WORDS);
  localparam logic [31:0] CS_MASK  = (32'(NR_CS) - 32'd1) << CS_ADDR_BIT;

  splitter_state_t r_state, w_next_state;

  logic [31:0]          r_addr;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [LEN_WIDTH-1:0] r_total;
  logic [LEN_WIDTH-1:0] r_rx_cnt;
  logic [LEN_WIDTH-1:0] r_chunk;
  logic                 r_write;
  logic                 r_reg_space;
  logic                 r_err;
  logic [31:0]          r_trans_addr;
  logic [NR_CS-1:0]     r_trans_cs;

  logic [LEN_WIDTH-1:0] w_chunk;
  logic                 w_bad_req;
  logic                 w_last;
  logic                 w_rx_beat;
  logic                 w_counting;

  hyperbus_chunk_calc #(
    .LEN_WIDTH      (LEN_WIDTH),
    .MAX_BURST      (MAX_BURST),
    .BOUNDARY_WORDS (BOUNDARY_WORDS),
    .BND_BITS       (BND_BITS)
  ) u_chunk_calc (
    .addr_lo_i   (r_addr[BND_BITS-1:0]),
    .remaining_i (r_remaining),
    .reg_space_i (r_reg_space),
    .chunk_o     (w_chunk)
  );

  assign w_bad_req  = (req_len_i == '0) || (req_reg_space_i && (req_len_i != LEN_WIDTH'(1)));
  assign w_last     = (r_remaining == r_chunk);
  assign w_rx_beat  = rx_valid_i && rx_ready_i;
  assign w_counting = (r_state == S_CALC) || (r_state == S_ISSUE) || (r_state == S_WAIT_RX);

  assign trans_address_o       = r_trans_addr;
  assign trans_cs_o            = r_trans_cs;
  assign trans_write_o         = r_write;
  assign trans_burst_o         = BURST_WIDTH'(r_chunk);
  assign trans_address_space_o = r_reg_space;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    req_ready_o   = 1'b0;
    trans_valid_o = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_next_state = w_bad_req ? S_DONE : S_CALC;
      end
      S_CALC: w_next_state = S_ISSUE;
      S_ISSUE: begin
        trans_valid_o = 1'b1;
        if (trans_ready_i) begin
          if (!w_last)      w_next_state = S_CALC;
          else if (r_write) w_next_state = S_DONE;
          else              w_next_state = S_WAIT_RX;
        end
      end
      // Also covers the count having been reached while transactions were still being issued.
      S_WAIT_RX: if (r_rx_cnt == r_total) w_next_state = S_DONE;
      S_DONE: begin
        done_o       = 1'b1;
        err_o        = r_err;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_total      <= '0;
      r_rx_cnt     <= '0;
      r_chunk      <= '0;
      r_write      <= 1'b0;
      r_reg_space  <= 1'b0;
      r_err        <= 1'b0;
      r_trans_addr <= '0;
      r_trans_cs   <= '0;
    end else begin
      if (r_state == S_IDLE && req_valid_i) begin
        r_addr      <= req_addr_i;
        r_remaining <= req_len_i;
        r_total     <= req_len_i;
        r_write     <= req_write_i;
        r_reg_space <= req_reg_space_i;
        r_err       <= w_bad_req;
        r_rx_cnt    <= '0;
      end else if (w_counting && w_rx_beat && (r_rx_cnt != r_total)) begin
        r_rx_cnt <= r_rx_cnt + LEN_WIDTH'(1);
      end

      if (r_state == S_CALC) begin
        r_chunk      <= w_chunk;
        r_trans_addr <= r_addr & ~CS_MASK;
        r_trans_cs   <= NR_CS'(1) << r_addr[CS_ADDR_BIT +: CS_W];
      end

      if (r_state == S_ISSUE && trans_ready_i) begin
        r_addr      <= r_addr + 32'(r_chunk);
        r_remaining <= r_remaining - r_chunk;
      end

      if (r_state == S_DONE) r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// tb/tb_hyperbus_burst_splitter.sv - directed self-checking bench for hyperbus_burst_splitter
module tb_hyperbus_burst_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic        req_write;
  logic        req_reg;
  logic        trans_valid;
  logic        trans_ready;
  logic [31:0] trans_address;
  logic [1:0]  trans_cs;
  logic        trans_write;
  logic [11:0] trans_burst;
  logic        trans_space;
  logic        rx_valid;
  logic        rx_ready;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hyperbus_burst_splitter dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .req_valid_i           (req_valid),
    .req_ready_o           (req_ready),
    .req_addr_i            (req_addr),
    .req_len_i             (req_len),
    .req_write_i           (req_write),
    .req_reg_space_i       (req_reg),
    .trans_valid_o         (trans_valid),
    .trans_ready_i         (trans_ready),
    .trans_address_o       (trans_address),
    .trans_cs_o            (trans_cs),
    .trans_write_o         (trans_write),
    .trans_burst_o         (trans_burst),
    .trans_address_space_o (trans_space),
    .rx_valid_i            (rx_valid),
    .rx_ready_i            (rx_ready),
    .done_o                (done),
    .err_o                 (err)
  );

  task automatic send_req(input logic [31:0] a, input logic [15:0] len,
                          input logic w, input logic sp);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_addr = a; req_len = len; req_write = w; req_reg = sp;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic expect_trans(input logic [31:0] a, input logic [1:0] cs,
                              input logic [11:0] b, input logic w, input logic sp);
    int waited = 0;
    while (trans_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (waited != 1) begin
      n_err++;
      $display("FAIL trans_latency @%h: got %0d cycles want 1", a, waited);
    end
    n_vec++;
    if (trans_address !== a || trans_cs !== cs || trans_burst !== b ||
        trans_write !== w || trans_space !== sp) begin
      n_err++;
      $display("FAIL trans_payload: got addr=%h cs=%b burst=%0d w=%b sp=%b want addr=%h cs=%b burst=%0d w=%b sp=%b",
               trans_address, trans_cs, trans_burst, trans_write, trans_space, a, cs, b, w, sp);
    end
    trans_ready = 1'b1;
    @(negedge clk);
    trans_ready = 1'b0;
  endtask

  task automatic rx_beats(input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1; rx_ready = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0; rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || trans_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy=%b tv=%b done=%b err=%b want 1 0 0 0", req_ready, trans_valid, done, err);
    end
    n_vec++;
    if (trans_address !== 32'h0 || trans_cs !== 2'b00 || trans_burst !== 12'd0 ||
        trans_write !== 1'b0 || trans_space !== 1'b0) begin
      n_err++;
      $display("FAIL reset_payload: got addr=%h cs=%b burst=%0d want all zero", trans_address, trans_cs, trans_burst);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_single;
    send_req(32'h10, 16'd8, 1'b0, 1'b0);
    expect_trans(32'h10, 2'b01, 12'd8, 1'b0, 1'b0);
    rx_beats(8);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL read_single_early_done: got %b want 0", done); end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL read_single_done: got done=%b err=%b want 1 0", done, err);
    end
  endtask

  task automatic test_write_split;
    send_req(32'h3F0, 16'd600, 1'b1, 1'b0);
    expect_trans(32'h3F0, 2'b01, 12'd16,  1'b1, 1'b0);
    expect_trans(32'h400, 2'b01, 12'd256, 1'b1, 1'b0);
    expect_trans(32'h500, 2'b01, 12'd256, 1'b1, 1'b0);
    expect_trans(32'h600, 2'b01, 12'd72,  1'b1, 1'b0);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL write_split_done: got done=%b err=%b want 1 0", done, err);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL write_split_idle: got done=%b rdy=%b want 0 1", done, req_ready);
    end
  endtask

  task automatic test_cs_cross;
    send_req(32'h7FFFFC, 16'd8, 1'b0, 1'b0);
    expect_trans(32'h7FFFFC, 2'b01, 12'd4, 1'b0, 1'b0);
    expect_trans(32'h000000, 2'b10, 12'd4, 1'b0, 1'b0);
    rx_beats(8);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL cs_cross_done: got done=%b err=%b want 1 0", done, err);
    end
  endtask

  task automatic test_errors;
    logic [15:0] lens [2] = '{16'd0, 16'd2};
    logic        regs [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      send_req(32'h80, lens[k], 1'b0, regs[k]);
      n_vec++;
      if (done !== 1'b1 || err !== 1'b1 || trans_valid !== 1'b0) begin
        n_err++;
        $display("FAIL error_req%0d: got done=%b err=%b tv=%b want 1 1 0", k, done, err, trans_valid);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1 || trans_valid !== 1'b0) begin
        n_err++;
        $display("FAIL error_after%0d: got done=%b err=%b rdy=%b tv=%b want 0 0 1 0", k, done, err, req_ready, trans_valid);
      end
    end
  endtask

  task automatic test_reg_single;
    send_req(32'h5, 16'd1, 1'b0, 1'b1);
    expect_trans(32'h5, 2'b01, 12'd1, 1'b0, 1'b1);
    rx_beats(1);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reg_single_done: got done=%b err=%b want 1 0", done, err);
    end
  endtask

  task automatic test_stall;
    int waited = 0;
    send_req(32'h20, 16'd4, 1'b0, 1'b0);
    while (trans_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (trans_valid !== 1'b1 || trans_address !== 32'h20 || trans_burst !== 12'd4 || trans_cs !== 2'b01) begin
        n_err++;
        $display("FAIL stall_hold%0d: got tv=%b addr=%h burst=%0d cs=%b want 1 00000020 4 01",
                 i, trans_valid, trans_address, trans_burst, trans_cs);
      end
      rx_valid = 1'b1;
      rx_ready = (i % 2 == 0);
      @(negedge clk);
    end
    rx_valid = 1'b0; rx_ready = 1'b0;
    trans_ready = 1'b1;
    @(negedge clk);
    trans_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL stall_early_done%0d: got %b want 0", i, done); end
      @(negedge clk);
    end
    rx_beats(1);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL stall_last_beat: got done=%b want 0", done); end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL stall_done: got done=%b err=%b want 1 0", done, err);
    end
  endtask

  task automatic test_early_rx;
    int waited = 0;
    send_req(32'h40, 16'd2, 1'b0, 1'b0);
    while (trans_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    rx_beats(3);
    trans_ready = 1'b1;
    @(negedge clk);
    trans_ready = 1'b0;
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL early_rx_wait: got done=%b want 0", done); end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL early_rx_done: got done=%b err=%b want 1 0", done, err);
    end
  endtask

  task automatic test_reset_mid;
    int waited = 0;
    @(negedge clk);
    send_req(32'h0, 16'd8, 1'b1, 1'b0);
    while (trans_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (trans_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got tv=%b rdy=%b done=%b want 0 1 0", trans_valid, req_ready, done);
    end
    rst = 1'b0;
    send_req(32'h100, 16'd4, 1'b1, 1'b0);
    expect_trans(32'h100, 2'b01, 12'd4, 1'b1, 1'b0);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_fresh: got done=%b err=%b want 1 0", done, err);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_write = 1'b0; req_reg = 1'b0;
    trans_ready = 1'b0; rx_valid = 1'b0; rx_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_single();
    @(negedge clk);
    test_write_split();
    test_cs_cross();
    test_errors();
    @(negedge clk);
    test_reg_single();
    @(negedge clk);
    test_stall();
    @(negedge clk);
    test_early_rx();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
